// File: rtl/shift_seq_pkg.sv
// Shared types and helpers for the shift sequencer.
// The optional abort path is enabled by defining SHIFT_SEQ_ABORT_EN.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Width of a counter that must hold the values 0..range-1.
    function automatic int cnt_width(input int range);
        return (range <= 2) ? 1 : $clog2(range);
    endfunction

endpackage

// File: rtl/shift_tick_gen.sv
// Shift-rate divider: counts 0..DIV-1 while enabled and flags the last count.
// The clear input wins over the enable.
module shift_tick_gen
    import shift_seq_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int CW = cnt_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_count;
    logic          w_at_last;

    assign w_at_last = (r_count == LAST);
    assign o_tick    = i_en && w_at_last;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_at_last ? '0 : r_count + CW'(1);
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Frames one N-bit serial transfer: a load strobe, N shift strobes DIV clocks apart, then done.
// Defining SHIFT_SEQ_ABORT_EN adds the i_abort input that cancels a frame in LOAD or SHIFT.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter  int N   = 8,
    parameter  int DIV = 4,
    localparam int BW  = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic          i_abort,
`endif
    output logic          o_ready,
    output logic          o_load,
    output logic          o_shift,
    output logic [BW-1:0] o_bit_idx,
    output logic          o_done,
    output seq_state_t    o_state
);

    // Handshake: i_start acts as valid; a frame is accepted on a clock edge where
    // i_start && o_ready. o_ready is a pure decode of IDLE, so nothing is queued.

    localparam logic [BW-1:0] LAST_IDX = BW'(N - 1);

    seq_state_t    r_state;
    seq_state_t    w_next;
    logic [BW-1:0] r_bit_idx;
    logic [BW-1:0] w_bit_idx_next;
    logic          w_tick;
    logic          w_tick_en;
    logic          w_tick_clr;

    assign w_tick_en = (r_state == SHIFT);

`ifdef SHIFT_SEQ_ABORT_EN
    logic w_abort_hit;
    assign w_abort_hit = i_abort && ((r_state == LOAD) || (r_state == SHIFT));
    assign w_tick_clr  = (r_state == LOAD) || w_abort_hit;
`else
    assign w_tick_clr  = (r_state == LOAD);
`endif

    shift_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_tick_clr),
        .i_en    (w_tick_en),
        .o_tick  (w_tick)
    );

    always_comb begin
        w_next         = r_state;
        w_bit_idx_next = r_bit_idx;
        o_ready        = 1'b0;
        o_load         = 1'b0;
        o_shift        = 1'b0;
        o_done         = 1'b0;
        case (r_state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_start) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                o_load         = 1'b1;
                w_bit_idx_next = '0;
                w_next         = SHIFT;
            end
            SHIFT: begin
                if (w_tick) begin
                    o_shift = 1'b1;
                    // The last bit leaves the index at N-1 so it never wraps.
                    if (r_bit_idx == LAST_IDX) begin
                        w_next = DONE;
                    end else begin
                        w_bit_idx_next = r_bit_idx + BW'(1);
                    end
                end
            end
            DONE: begin
                o_done = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
`ifdef SHIFT_SEQ_ABORT_EN
        if (w_abort_hit) begin
            o_shift        = 1'b0;
            o_done         = 1'b0;
            w_bit_idx_next = '0;
            w_next         = IDLE;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_bit_idx <= '0;
        end else begin
            r_state   <= w_next;
            r_bit_idx <= w_bit_idx_next;
        end
    end

    assign o_bit_idx = r_bit_idx;
    assign o_state   = r_state;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: two configurations (N=8/DIV=4 and N=2/DIV=1) share one stimulus
// stream and are checked every cycle against a frame-timing model; SHIFT_SEQ_ABORT_EN adds abort tests.
module tb_shift_sequencer;
    import shift_seq_pkg::*;

    localparam int NA = 8;
    localparam int DA = 4;
    localparam int NB = 2;
    localparam int DB = 1;
`ifdef SHIFT_SEQ_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    always #5 clk = ~clk;

    logic       a_ready, a_load, a_shift, a_done;
    logic [2:0] a_idx;
    seq_state_t a_state;
    logic       b_ready, b_load, b_shift, b_done;
    logic [0:0] b_idx;
    seq_state_t b_state;

    shift_sequencer #(.N(NA), .DIV(DA)) dut_a (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_start   (start),
`ifdef SHIFT_SEQ_ABORT_EN
        .i_abort   (abort),
`endif
        .o_ready   (a_ready),
        .o_load    (a_load),
        .o_shift   (a_shift),
        .o_bit_idx (a_idx),
        .o_done    (a_done),
        .o_state   (a_state)
    );

    shift_sequencer #(.N(NB), .DIV(DB)) dut_b (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_start   (start),
`ifdef SHIFT_SEQ_ABORT_EN
        .i_abort   (abort),
`endif
        .o_ready   (b_ready),
        .o_load    (b_load),
        .o_shift   (b_shift),
        .o_bit_idx (b_idx),
        .o_done    (b_done),
        .o_state   (b_state)
    );

    // ---------------- model / scoreboard state ----------------
    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int cfg_n[2]   = '{NA, NB};
    int cfg_div[2] = '{DA, DB};
    int m_s[2]     = '{-1, -1};   // cycle at which the current frame's start was accepted
    int m_idx[2]   = '{0, 0};     // bit_idx value held outside a frame
    logic [31:0] exp_q_a[$];      // expected shift cycles, configuration A
    logic [31:0] exp_q_b[$];      // expected shift cycles, configuration B
    int a_shift_cnt = 0;
    int a_done_cnt  = 0;

    function automatic bit in_frame(input int d);
        int len;
        len = 2 + cfg_n[d] * cfg_div[d];
        return (m_s[d] >= 0) && (cyc > m_s[d]) && (cyc <= m_s[d] + len);
    endfunction

    task automatic check_dut(input int d, input logic ready, input logic load, input logic shift,
                             input logic done, input int idx, input seq_state_t st);
        int   n, dv, rel, e_idx;
        logic busy, e_ready, e_load, e_shift, e_done;
        logic [31:0] head;
        n     = cfg_n[d];
        dv    = cfg_div[d];
        busy  = in_frame(d);
        rel   = cyc - m_s[d];
        e_load  = busy && (rel == 1);
        e_shift = busy && (rel >= 1 + dv) && (rel <= 1 + n * dv) && ((rel - 1) % dv == 0);
        e_done  = busy && (rel == 2 + n * dv);
        e_ready = !busy;
        e_idx   = m_idx[d];
        if (busy && rel >= 2) e_idx = ((rel - 2) / dv < n - 1) ? (rel - 2) / dv : n - 1;
        if (ABORT_EN && abort && busy && rel <= 1 + n * dv) e_shift = 1'b0;

        n_cmp++;
        if (ready !== e_ready) begin
            n_err++;
            $display("FAIL ready[%0d] cyc %0d: got %b want %b", d, cyc, ready, e_ready);
        end
        n_cmp++;
        if (load !== e_load) begin
            n_err++;
            $display("FAIL load[%0d] cyc %0d: got %b want %b", d, cyc, load, e_load);
        end
        n_cmp++;
        if (shift !== e_shift) begin
            n_err++;
            $display("FAIL shift[%0d] cyc %0d: got %b want %b", d, cyc, shift, e_shift);
        end
        n_cmp++;
        if (done !== e_done) begin
            n_err++;
            $display("FAIL done[%0d] cyc %0d: got %b want %b", d, cyc, done, e_done);
        end
        n_cmp++;
        if (idx !== e_idx) begin
            n_err++;
            $display("FAIL bit_idx[%0d] cyc %0d: got %0d want %0d", d, cyc, idx, e_idx);
        end
        n_cmp++;
        if ((st == IDLE) !== e_ready) begin
            n_err++;
            $display("FAIL state_idle[%0d] cyc %0d: got %b want %b", d, cyc, (st == IDLE), e_ready);
        end
        if (shift === 1'b1) begin
            n_cmp++;
            if ((d == 0 && exp_q_a.size() == 0) || (d == 1 && exp_q_b.size() == 0)) begin
                n_err++;
                $display("FAIL shift_sched[%0d] cyc %0d: got unexpected shift want none", d, cyc);
            end else begin
                head = (d == 0) ? exp_q_a.pop_front() : exp_q_b.pop_front();
                if (head !== 32'(cyc)) begin
                    n_err++;
                    $display("FAIL shift_sched[%0d]: got cyc %0d want cyc %0d", d, cyc, head);
                end
            end
        end
        m_idx[d] = e_idx;
    endtask

    task automatic update_model(input int d);
        int n, dv;
        n  = cfg_n[d];
        dv = cfg_div[d];
        if (rst) begin
            m_s[d] = -1;
            m_idx[d] = 0;
            if (d == 0) exp_q_a.delete(); else exp_q_b.delete();
        end else if (ABORT_EN && abort && in_frame(d) && (cyc - m_s[d] <= 1 + n * dv)) begin
            m_s[d] = -1;
            m_idx[d] = 0;
            if (d == 0) exp_q_a.delete(); else exp_q_b.delete();
        end else if (!in_frame(d) && start) begin
            m_s[d] = cyc;
            for (int k = 1; k <= n; k++) begin
                if (d == 0) exp_q_a.push_back(32'(cyc + 1 + k * dv));
                else        exp_q_b.push_back(32'(cyc + 1 + k * dv));
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic s, input logic r, input logic a);
        start = s;
        rst   = r;
        abort = a;
        @(negedge clk);
        check_dut(0, a_ready, a_load, a_shift, a_done, int'(a_idx), a_state);
        check_dut(1, b_ready, b_load, b_shift, b_done, int'(b_idx), b_state);
        if (a_shift === 1'b1) a_shift_cnt++;
        if (a_done === 1'b1) a_done_cnt++;
        update_model(0);
        update_model(1);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
        a_shift_cnt = 0;
        a_done_cnt  = 0;
    endtask

    task automatic check_counts(input string name, input int want_shift, input int want_done);
        n_cmp++;
        if (a_shift_cnt !== want_shift) begin
            n_err++;
            $display("FAIL %s shift_count: got %0d want %0d", name, a_shift_cnt, want_shift);
        end
        n_cmp++;
        if (a_done_cnt !== want_done) begin
            n_err++;
            $display("FAIL %s done_count: got %0d want %0d", name, a_done_cnt, want_done);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        idle_cycles(2);
    endtask

    task automatic test_single_frame();
        for (int t = 0; t < 40; t++) step(t == 0, 1'b0, 1'b0);
        check_counts("single_frame", NA, 1);
        idle_cycles(4);
    endtask

    task automatic test_start_ignored();
        for (int t = 0; t < 40; t++) step((t == 0) || (t == 3) || (t == 20), 1'b0, 1'b0);
        check_counts("start_ignored", NA, 1);
        idle_cycles(4);
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 80; t++) step(1'b1, 1'b0, 1'b0);
        for (int t = 0; t < 40; t++) step(1'b0, 1'b0, 1'b0);
        check_counts("back_to_back", 3 * NA, 3);
        idle_cycles(4);
    endtask

    task automatic test_mid_reset();
        for (int t = 0; t < 60; t++) step((t == 0) || (t == 22), t == 20, 1'b0);
        check_counts("mid_reset", 4 + NA, 1);
        idle_cycles(4);
    endtask

`ifdef SHIFT_SEQ_ABORT_EN
    task automatic test_abort();
        for (int t = 0; t < 20; t++) step(t == 0, 1'b0, t == 12);
        check_counts("abort_mid", 2, 0);
        idle_cycles(4);
        for (int t = 0; t < 20; t++) step(t == 0, 1'b0, t == 13);
        check_counts("abort_on_shift", 2, 0);
        idle_cycles(4);
    endtask
`endif

    task automatic test_random();
        logic s, r, a;
        for (int t = 0; t < 1500; t++) begin
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 199) == 0);
            a = ABORT_EN && ($urandom_range(0, 29) == 0);
            step(s, r, a);
        end
        idle_cycles(60);
        n_cmp++;
        if (exp_q_a.size() != 0 || exp_q_b.size() != 0) begin
            n_err++;
            $display("FAIL pending_shifts: got %0d/%0d left want 0/0", exp_q_a.size(), exp_q_b.size());
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_single_frame();
        test_start_ignored();
        test_back_to_back();
        test_mid_reset();
`ifdef SHIFT_SEQ_ABORT_EN
        test_abort();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Controller that frames one N-bit serial transfer on a parallel-load shift register.
- Issues a single load strobe, then exactly N shift strobes spaced DIV clocks apart, then a one-cycle done pulse.
- Sits between the datapath's start/ready handshake and the shift register's load/shift enables.
- Contains the bit counter and shift-rate divider, so the shift register itself carries no counting logic.

Parameters:
- N, 8, bits per frame; legal range N >= 2
- DIV, 4, clock cycles per shift step; legal range DIV >= 1
- BW, $clog2(N), width of bit_idx (derived; not overridden)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  frame request; sampled only in IDLE
- ready  out  1  high only in IDLE; combinational decode of state
- load  out  1  one-cycle parallel-load strobe to the shift register
- shift  out  1  one-cycle shift-enable strobe to the shift register
- bit_idx  out  BW  index of the bit being shifted, 0..N-1
- done  out  1  one-cycle pulse, frame complete
- abort  in  1  present only with SHIFT_SEQ_ABORT_EN

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset: state=IDLE, divider=0, bit_idx=0, load=shift=done=0. ready=1 from the first clk edge with reset high.
- Reset priority: reset overrides every other input in any state, including mid-frame.
- Outputs load, shift and done are registered or state-decoded. They are never high in the same cycle.
- IDLE: ready=1. If start=1, next state is LOAD; otherwise stay in IDLE.
- LOAD: lasts one cycle, with load=1. Clears the divider and bit_idx. Next state is SHIFT.
- SHIFT:
  - The divider counts 0..DIV-1.
  - In the cycle where divider==DIV-1: shift=1 and the divider wraps to 0.
  - On that same cycle: if bit_idx==N-1, next state is DONE and bit_idx holds; otherwise bit_idx increments.
  - DIV=1 means shift is high every SHIFT cycle.
- DONE: lasts one cycle, with done=1. Next state is IDLE. bit_idx holds N-1 until the next LOAD.
- Timing, with start sampled at cycle s:
  - load at s+1
  - shift at s+1+k*DIV for k=1..N
  - done at s+2+N*DIV
  - ready=1 at s+3+N*DIV
- Start handling:
  - start is ignored outside IDLE; there is no queuing.
  - Holding start high gives back-to-back frames with exactly one IDLE cycle between them.
- Exactly N shift pulses per completed frame, never more.
- Divider and bit_idx never wrap past their ranges.

Optional Feature:
- Macro: SHIFT_SEQ_ABORT_EN.
- When defined:
  - abort port exists.
  - abort=1 in LOAD or SHIFT sets next state to IDLE.
  - That cycle, shift and done are forced 0; abort wins over a coincident shift pulse.
  - Divider and bit_idx clear to 0.
  - abort is ignored in IDLE and DONE.
- When undefined: no abort port; the FSM has no abort paths.

Decomposition:
- Package shift_seq_pkg holds:
  - typedef enum logic [1:0] seq_state_t {IDLE, LOAD, SHIFT, DONE}
  - function returning the counter width for a given range.
- Sub-module shift_tick_gen #(DIV) contains the divider only.
  - Inputs: clk, reset, clr, en. Output: tick.
  - tick is high when count==DIV-1 and en=1.
- The sequencer FSM and bit counter stay in shift_sequencer.

Test Plan:
- N=8, DIV=4, start pulsed at cycle 0 -> load@1; shift@5,9,13,17,21,25,29,33; bit_idx 0..7; done@34; ready@35.
- Same configuration, start held high -> second load@36; exactly 8 shifts per frame; done never overlaps load or shift.
- start pulses at cycles 3 and 20 during a frame -> ignored; single done@34; shift count=8.
- Reset asserted at cycle 20 mid-SHIFT -> at cycle 21: ready=1, bit_idx=0, load/shift/done=0; next start is honored normally.
- N=2, DIV=1, start@0 -> load@1, shift@2,3, done@4, ready@5.
- With SHIFT_SEQ_ABORT_EN, abort@12 -> shifts only @5,9; ready@13; no done.
- With SHIFT_SEQ_ABORT_EN, abort coincident with shift@13 -> no shift@13; ready@14.
